decoder_seq_nx2n: RTL and testbench
===================================

// Module: decoder_seq_nx2n
// PURPOSE
//  Parametrised, registered N-to-2^N one-hot decoder with enable and a built-in scan sequencer.
//  DECODE mode: registers the one-hot decode of each accepted input code.
//  SCAN mode: steps a single active output through all 2^N lines at a programmable rate.
//  Drives select/strobe lines for banked peripherals; replaces the fixed combinational 3x8 decoder.
// PARAMETERS
//  N         3   input code width; outputs = 2**N (localparam NOUT); N >= 1
//  SCAN_DIV  4   cycles each output stays active in SCAN mode; SCAN_DIV >= 1
// PORTS
//  CLK       in   1       single clock, rising edge
//  RST_N     in   1       asynchronous active-low reset
//  EN        in   1       block enable; 0 forces outputs off
//  MODE      in   1       0 = DECODE, 1 = SCAN
//  I         in   N       code to decode (DECODE) / scan start index (SCAN entry)
//  I_VALID   in   1       code valid (DECODE mode only)
//  I_READY   out  1       = EN & ~MODE (combinational); code accepted on I_VALID & I_READY
//  M         out  NOUT    registered one-hot output; M[k] active for code k
//  M_VALID   out  1       M holds a meaningful value
//  BUSY      out  1       1 while in SCAN state
// BEHAVIOUR
//  Reset (RST_N=0, async):
//   - M=0, M_VALID=0, BUSY=0, state=IDLE, scan index=0, divider=0.
//   - Applies immediately, including mid-scan.
//  States: IDLE, DECODE, SCAN (registered state, evaluated every cycle).
//   - EN=0: from any state -> IDLE next edge; M=0, M_VALID=0 next cycle. EN dominates MODE and I_VALID.
//   - EN=1, MODE=0: -> DECODE.
//   - EN=1, MODE=1: -> SCAN.
//  DECODE:
//   - On handshake, M <= 1<<I and M_VALID <= 1; latency exactly 1 cycle.
//   - M holds until the next handshake; back-to-back codes are accepted every cycle.
//   - Entering DECODE from IDLE or SCAN: M=0, M_VALID=0 until the first handshake.
//  SCAN:
//   - Entry cycle: index <= I, M <= 1<<I, M_VALID <= 1, BUSY <= 1, divider cleared.
//   - Divider counts 0..SCAN_DIV-1; on terminal count index increments and the divider restarts.
//   - Index wraps NOUT-1 -> 0 (modulo 2**N, no gap cycle); each output is active exactly SCAN_DIV cycles.
//   - SCAN_DIV=1: advance every cycle.
//   - I_VALID is ignored (I_READY=0). I is sampled only on the entry cycle.
//   - Leaving SCAN (MODE->0 or EN->0): M=0, BUSY=0 next cycle; scan position is not retained.
//  Arithmetic: index is N bits, divider is $clog2(SCAN_DIV+1) bits; no X propagation; M is never multi-hot.
// CONFIGURATION
//  DEC_WRAP_PULSE_EN defined:
//   - Adds output WRAP (1 bit, reset 0).
//   - WRAP is a registered one-cycle pulse, coincident with M changing from bit NOUT-1 to bit 0 in SCAN.
//   - No pulse on the SCAN entry cycle, even when I=0.
//  DEC_WRAP_PULSE_EN undefined: WRAP port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package decoder_pkg:
//   - typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_SCAN} dec_state_t
//   - function onehot(idx, width)
//  Sub-module scan_divider (param DIV; ports CLK, RST_N, CLR, EN, TICK):
//   - Prescaler producing a one-cycle TICK every DIV enabled cycles; CLR restarts the count.
//  Top level: state register, index register, output register, handshake logic.
// TESTING (N=3, SCAN_DIV=2 unless noted)
//  1. Reset: RST_N=0 -> M=0, M_VALID=0, BUSY=0, I_READY=0. Release with EN=1, MODE=0 -> I_READY=1.
//  2. Decode sweep: EN=1, MODE=0, I_VALID=1, I=0..7 on consecutive cycles
//     -> M=8'h01..8'h80 each one cycle later; M_VALID=1.
//  3. Scan wrap: MODE=1, I=6 at entry -> M=8'h40 x2, 8'h80 x2, 8'h01 x2, 8'h02...;
//     with DEC_WRAP_PULSE_EN, WRAP=1 only in the first 8'h01 cycle.
//  4. EN drop mid-scan with I_VALID=1 -> next cycle M=0, M_VALID=0, BUSY=0;
//     re-enable with MODE=0 and no handshake -> M stays 0.
//  5. Async reset mid-scan, asserted between clock edges -> outputs clear immediately, before the next edge.
//  6. SCAN_DIV=1, N=2: MODE=1, I=0 -> M=1,2,4,8,1,... changing every cycle.

Source files
------------

// File: rtl/decoder_seq_nx2n_pkg.sv
// Shared types and helpers for the sequenced N-to-2^N decoder.
// Used by decoder_seq_nx2n and its scan_divider prescaler.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } dec_state_t;

  // Widest decode the helper supports; callers cast the result down to their own width.
  localparam int ONEHOT_IDX_W = 8;
  localparam int ONEHOT_W     = 1 << ONEHOT_IDX_W;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_IDX_W-1:0] idx,
                                                 input int unsigned             width);
    onehot = '0;
    if (32'(idx) < width) onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_seq_nx2n_scan_divider.sv
// Prescaler for the scan sequencer: one-cycle tick every DIV enabled cycles.
// clr restarts the count from zero and suppresses the tick in that cycle.
module scan_divider
  import decoder_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = en & ~clr & (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_seq_nx2n.sv
// Registered N-to-2^N one-hot decoder with enable and a built-in scan sequencer.
// Optional DEC_WRAP_PULSE_EN adds a one-cycle wrap output when the scan rolls over to line 0.
module decoder_seq_nx2n
  import decoder_pkg::*;
#(
  parameter int N        = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        i,
  input  logic                i_valid,
  output logic                i_ready,
  output logic [(1<<N)-1:0]   m,
  output logic                m_valid,
  output logic                busy
`ifdef DEC_WRAP_PULSE_EN
  ,
  output logic                wrap
`endif
);

  localparam int NOUT = 1 << N;

  dec_state_t      state, state_d;
  logic [N-1:0]    idx, idx_d, idx_inc;
  logic [NOUT-1:0] m_d;
  logic            m_valid_d;
  logic            handshake;
  logic            scan_entry;
  logic            scan_run;
  logic            tick;

  assign i_ready    = en & ~mode;
  assign handshake  = i_valid & i_ready;
  assign idx_inc    = idx + 1'b1;
  assign busy       = (state == ST_SCAN);
  assign scan_run   = (state == ST_SCAN);
  assign scan_entry = (state_d == ST_SCAN) && (state != ST_SCAN);

  always_comb begin
    state_d = ST_IDLE;
    if (en) state_d = mode ? ST_SCAN : ST_DECODE;
  end

  // Output and index next-values; entering a new mode always starts from a clean output.
  always_comb begin
    m_d       = m;
    m_valid_d = m_valid;
    idx_d     = idx;
    unique case (state_d)
      ST_DECODE: begin
        idx_d = '0;
        if (state != ST_DECODE) begin
          m_d       = '0;
          m_valid_d = 1'b0;
        end
        if (handshake) begin
          m_d       = NOUT'(onehot(ONEHOT_IDX_W'(i), NOUT));
          m_valid_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_entry) begin
          idx_d     = i;
          m_d       = NOUT'(onehot(ONEHOT_IDX_W'(i), NOUT));
          m_valid_d = 1'b1;
        end else if (tick) begin
          idx_d = idx_inc;
          m_d   = NOUT'(onehot(ONEHOT_IDX_W'(idx_inc), NOUT));
        end
      end
      default: begin
        idx_d     = '0;
        m_d       = '0;
        m_valid_d = 1'b0;
      end
    endcase
  end

  scan_divider #(
    .DIV (SCAN_DIV)
  ) u_scan_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scan_entry),
    .en    (scan_run),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      m       <= '0;
      m_valid <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      m       <= m_d;
      m_valid <= m_valid_d;
    end
  end

`ifdef DEC_WRAP_PULSE_EN
  logic wrap_d;

  // Only a real advance out of the top line counts; the entry cycle never pulses.
  assign wrap_d = (state == ST_SCAN) && (state_d == ST_SCAN) && tick && (&idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= wrap_d;
  end
`endif

endmodule

// File: tb/tb_decoder_seq_nx2n.sv
// Self-checking bench for decoder_seq_nx2n (N=3/SCAN_DIV=2 and N=2/SCAN_DIV=1 instances).
// Expected outputs are queued as stimulus is applied and popped after each clock.
module tb_decoder_seq_nx2n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, i_valid;
  logic [2:0] i;
  logic       i_ready, m_valid, busy;
  logic [7:0] m;
  logic       wrap;

  logic       en2, mode2, iv2;
  logic [1:0] i2;
  logic       i_ready2, m_valid2, busy2;
  logic [3:0] m2;
  logic       wrap2;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [7:0] m;
    logic       mv;
    logic       busy;
    logic       wrap;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_seq_nx2n #(.N(3), .SCAN_DIV(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .m       (m),
    .m_valid (m_valid),
    .busy    (busy)
`ifdef DEC_WRAP_PULSE_EN
    ,
    .wrap    (wrap)
`endif
  );

  decoder_seq_nx2n #(.N(2), .SCAN_DIV(1)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en2),
    .mode    (mode2),
    .i       (i2),
    .i_valid (iv2),
    .i_ready (i_ready2),
    .m       (m2),
    .m_valid (m_valid2),
    .busy    (busy2)
`ifdef DEC_WRAP_PULSE_EN
    ,
    .wrap    (wrap2)
`endif
  );

`ifndef DEC_WRAP_PULSE_EN
  assign wrap  = 1'b0;
  assign wrap2 = 1'b0;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (m !== 8'h00)     begin fails++; $display("FAIL reset_m: got %h want 00", m); end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (i_ready !== 1'b0) begin fails++; $display("FAIL reset_i_ready: got %b want 0", i_ready); end
`ifdef DEC_WRAP_PULSE_EN
    checks++; if (wrap !== 1'b0)    begin fails++; $display("FAIL reset_wrap: got %b want 0", wrap); end
`endif
    en   = 1'b1;
    mode = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin fails++; $display("FAIL release_i_ready: got %b want 1", i_ready); end
    cyc();
  endtask

  task automatic test_decode_sweep();
    exp_t e;
    en   = 1'b1;
    mode = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        i       = 3'(k);
        i_valid = 1'b1;
        sb.push_back('{m: 8'(1 << k), mv: 1'b1, busy: 1'b0, wrap: 1'b0});
      end else begin
        i       = 3'd5;
        i_valid = 1'b0;
        sb.push_back('{m: 8'h80, mv: 1'b1, busy: 1'b0, wrap: 1'b0});
      end
      cyc();
      e = sb.pop_front();
      checks++; if (m !== e.m)        begin fails++; $display("FAIL decode_m step %0d: got %h want %h", k, m, e.m); end
      checks++; if (m_valid !== e.mv) begin fails++; $display("FAIL decode_m_valid step %0d: got %b want %b", k, m_valid, e.mv); end
      checks++; if (busy !== e.busy)  begin fails++; $display("FAIL decode_busy step %0d: got %b want %b", k, busy, e.busy); end
    end
  endtask

  task automatic test_scan_wrap();
    exp_t e;
    int   pos;
    mode    = 1'b1;
    i       = 3'd6;
    i_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pos = (6 + k / 2) % 8;
      sb.push_back('{m: 8'(1 << pos), mv: 1'b1, busy: 1'b1, wrap: (k == 4)});
      cyc();
      i = 3'd3;
      e = sb.pop_front();
      checks++; if (m !== e.m)        begin fails++; $display("FAIL scan_m step %0d: got %h want %h", k, m, e.m); end
      checks++; if (m_valid !== e.mv) begin fails++; $display("FAIL scan_m_valid step %0d: got %b want %b", k, m_valid, e.mv); end
      checks++; if (busy !== e.busy)  begin fails++; $display("FAIL scan_busy step %0d: got %b want %b", k, busy, e.busy); end
      checks++; if (i_ready !== 1'b0) begin fails++; $display("FAIL scan_i_ready step %0d: got %b want 0", k, i_ready); end
`ifdef DEC_WRAP_PULSE_EN
      checks++; if (wrap !== e.wrap)  begin fails++; $display("FAIL scan_wrap step %0d: got %b want %b", k, wrap, e.wrap); end
`endif
    end
  endtask

  task automatic test_en_drop();
    exp_t e;
    en      = 1'b0;
    i_valid = 1'b1;
    sb.push_back('{m: 8'h00, mv: 1'b0, busy: 1'b0, wrap: 1'b0});
    cyc();
    e = sb.pop_front();
    checks++; if (m !== e.m)        begin fails++; $display("FAIL endrop_m: got %h want %h", m, e.m); end
    checks++; if (m_valid !== e.mv) begin fails++; $display("FAIL endrop_m_valid: got %b want %b", m_valid, e.mv); end
    checks++; if (busy !== e.busy)  begin fails++; $display("FAIL endrop_busy: got %b want %b", busy, e.busy); end
    en      = 1'b1;
    mode    = 1'b0;
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{m: 8'h00, mv: 1'b0, busy: 1'b0, wrap: 1'b0});
      cyc();
      e = sb.pop_front();
      checks++; if (m !== e.m)        begin fails++; $display("FAIL reenable_m step %0d: got %h want %h", k, m, e.m); end
      checks++; if (m_valid !== e.mv) begin fails++; $display("FAIL reenable_m_valid step %0d: got %b want %b", k, m_valid, e.mv); end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    mode = 1'b1;
    i    = 3'd2;
    sb.push_back('{m: 8'h04, mv: 1'b1, busy: 1'b1, wrap: 1'b0});
    cyc();
    e = sb.pop_front();
    checks++; if (m !== e.m)       begin fails++; $display("FAIL prereset_m: got %h want %h", m, e.m); end
    checks++; if (busy !== e.busy) begin fails++; $display("FAIL prereset_busy: got %b want %b", busy, e.busy); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (m !== 8'h00)      begin fails++; $display("FAIL async_m: got %h want 00", m); end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL async_m_valid: got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL async_busy: got %b want 0", busy); end
    #2;
    en    = 1'b0;
    mode  = 1'b0;
    rst_n = 1'b1;
    cyc();
    checks++; if (m !== 8'h00) begin fails++; $display("FAIL postreset_m: got %h want 00", m); end
  endtask

  task automatic test_scan_div1();
    exp_t e;
    en2   = 1'b1;
    mode2 = 1'b1;
    i2    = 2'd0;
    iv2   = 1'b0;
    for (int k = 0; k < 9; k++) begin
      sb.push_back('{m: 8'(1 << (k % 4)), mv: 1'b1, busy: 1'b1, wrap: (k > 0) && (k % 4 == 0)});
      cyc();
      e = sb.pop_front();
      checks++; if ({4'b0, m2} !== e.m) begin fails++; $display("FAIL div1_m step %0d: got %h want %h", k, m2, e.m); end
      checks++; if (busy2 !== e.busy)   begin fails++; $display("FAIL div1_busy step %0d: got %b want %b", k, busy2, e.busy); end
`ifdef DEC_WRAP_PULSE_EN
      checks++; if (wrap2 !== e.wrap)   begin fails++; $display("FAIL div1_wrap step %0d: got %b want %b", k, wrap2, e.wrap); end
`endif
    end
    en2 = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    mode    = 1'b0;
    i       = 3'd0;
    i_valid = 1'b0;
    en2     = 1'b0;
    mode2   = 1'b0;
    i2      = 2'd0;
    iv2     = 1'b0;
    test_reset();
    test_decode_sweep();
    test_scan_wrap();
    test_en_drop();
    test_async_reset();
    test_scan_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
